mem_lsu: RTL

MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register. It consumes the latched ALU op, effective address and store operand, and runs a request/acknowledge transaction on the data bus. While the access is outstanding it stalls the pipeline. It then presents the register write-back triple (address, enable, data) to the MEM/WB register, together with address-error flags for the exception logic.

---
 rtl/mem_lsu_pkg.sv | 44 ++++
 rtl/mem_lsu_align.sv | 120 ++++++++++++
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - Bus widths (register, aluop, register-address).
//   - EXE_*_OP aluop codes for the memory instructions.
//   - FSM state encodings (IDLE/BUSY/DONE).
//   - Big-endian byte-lane select constants and the access-size type.
package mem_lsu_pkg;

  localparam int DATA_W    = 32;
  localparam int ALUOP_W   = 8;
  localparam int REGADDR_W = 5;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [ALUOP_W-1:0] EXE_SC_OP  = 8'b1111_1000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Big-endian: byte address 0 lives in bits [31:24] (lane 3).
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_B1   = 4'b0100;
  localparam logic [3:0] SEL_B2   = 4'b0010;
  localparam logic [3:0] SEL_B3   = 4'b0001;
  localparam logic [3:0] SEL_H0   = 4'b1100;
  localparam logic [3:0] SEL_H1   = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: combinational decode and data shaping for mem_lsu.
// Optional feature macro: LLSC_EN (decodes LL/SC as memory ops).
// Ports:
//   aluop_i       in  8   op from EX/MEM
//   addr_lo_i     in  2   low bits of the effective byte address
//   reg2_i        in  32  store operand
//   bus_data_i    in  32  raw load word from the bus
//   sel_o         out 4   big-endian byte lanes
//   store_data_o  out 32  store operand replicated onto the lanes
//   load_data_o   out 32  selected lane, sign/zero extended
//   is_load_o     out 1   op is a load (incl. LL)
//   is_store_o    out 1   op is a store (incl. SC)
//   is_ll_o       out 1   op is LL
//   is_sc_o       out 1   op is SC
//   misaligned_o  out 1   halfword/word address not naturally aligned
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [DATA_W-1:0]  reg2_i,
  input  logic [DATA_W-1:0]  bus_data_i,
  output logic [3:0]         sel_o,
  output logic [DATA_W-1:0]  store_data_o,
  output logic [DATA_W-1:0]  load_data_o,
  output logic               is_load_o,
  output logic               is_store_o,
  output logic               is_ll_o,
  output logic               is_sc_o,
  output logic               misaligned_o
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] sw;
    sb = signed'(b);
    sw = DATA_W'(sb);
    return sgn ? DATA_W'(sw) : {24'd0, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       sh;
    logic signed [DATA_W-1:0] sw;
    sh = signed'(h);
    sw = DATA_W'(sh);
    return sgn ? DATA_W'(sw) : {16'd0, h};
  endfunction

  size_e       size;
  logic        sgn;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size       = SZ_NONE;
    sgn        = 1'b0;
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    is_ll_o    = 1'b0;
    is_sc_o    = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin size = SZ_BYTE; is_load_o = 1'b1; sgn = 1'b1; end
      EXE_LBU_OP: begin size = SZ_BYTE; is_load_o = 1'b1; end
      EXE_LH_OP:  begin size = SZ_HALF; is_load_o = 1'b1; sgn = 1'b1; end
      EXE_LHU_OP: begin size = SZ_HALF; is_load_o = 1'b1; end
      EXE_LW_OP:  begin size = SZ_WORD; is_load_o = 1'b1; end
      EXE_SB_OP:  begin size = SZ_BYTE; is_store_o = 1'b1; end
      EXE_SH_OP:  begin size = SZ_HALF; is_store_o = 1'b1; end
      EXE_SW_OP:  begin size = SZ_WORD; is_store_o = 1'b1; end
`ifdef LLSC_EN
      EXE_LL_OP:  begin size = SZ_WORD; is_load_o = 1'b1; is_ll_o = 1'b1; end
      EXE_SC_OP:  begin size = SZ_WORD; is_store_o = 1'b1; is_sc_o = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_lane = bus_data_i[31:24];
      2'b01:   byte_lane = bus_data_i[23:16];
      2'b10:   byte_lane = bus_data_i[15:8];
      default: byte_lane = bus_data_i[7:0];
    endcase
    half_lane = addr_lo_i[1] ? bus_data_i[15:0] : bus_data_i[31:16];
  end

  always_comb begin
    sel_o        = 4'b0000;
    store_data_o = '0;
    load_data_o  = '0;
    case (size)
      SZ_BYTE: begin
        case (addr_lo_i)
          2'b00:   sel_o = SEL_B0;
          2'b01:   sel_o = SEL_B1;
          2'b10:   sel_o = SEL_B2;
          default: sel_o = SEL_B3;
        endcase
        store_data_o = {4{reg2_i[7:0]}};
        load_data_o  = ext_byte(byte_lane, sgn);
      end
      SZ_HALF: begin
        sel_o        = addr_lo_i[1] ? SEL_H1 : SEL_H0;
        store_data_o = {2{reg2_i[15:0]}};
        load_data_o  = ext_half(half_lane, sgn);
      end
      SZ_WORD: begin
        sel_o        = SEL_WORD;
        store_data_o = reg2_i;
        load_data_o  = bus_data_i;
      end
      default: ;
    endcase
  end

  assign misaligned_o = ((size == SZ_HALF) && addr_lo_i[0]) ||
                        ((size == SZ_WORD) && (addr_lo_i != 2'b00));

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Runs one req/ack bus transaction per
// memory op, stalls the pipeline while it is outstanding, and hands the
// write-back triple plus address-error flags to MEM/WB.
// Optional feature macro: LLSC_EN (LL/SC support and the LL bit).
// Ports:
//   clk, Rst_n (sync, active-low)   flush_i, stall_i, llbit_clr_i
//   aluop_i/mem_addr_i/reg2_i       op, byte address, store operand
//   wd_i/wreg_i/wdata_i             write-back request from EX/MEM
//   wd_o/wreg_o/wdata_o             write-back to MEM/WB
//   stallreq_o, adel_o, ades_o      stall request and address errors
//   bus_req_o/we/addr/sel/data_o    bus request side
//   bus_data_i, bus_ack_i           bus response side
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 Rst_n,
  input  logic                 flush_i,
  input  logic                 stall_i,
  input  logic                 llbit_clr_i,
  input  logic [ALUOP_W-1:0]   aluop_i,
  input  logic [DATA_W-1:0]    mem_addr_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 stallreq_o,
  output logic                 adel_o,
  output logic                 ades_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [DATA_W-1:0]    bus_addr_o,
  output logic [3:0]           bus_sel_o,
  output logic [DATA_W-1:0]    bus_data_o,
  input  logic [DATA_W-1:0]    bus_data_i,
  input  logic                 bus_ack_i
);

  logic [3:0]        sel;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_data;
  logic              is_load;
  logic              is_store;
  logic              is_ll;
  logic              is_sc;
  logic              misaligned;

  mem_align u_align (
    .aluop_i      (aluop_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .reg2_i       (reg2_i),
    .bus_data_i   (bus_data_i),
    .sel_o        (sel),
    .store_data_o (st_data),
    .load_data_o  (ld_data),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_ll_o      (is_ll),
    .is_sc_o      (is_sc),
    .misaligned_o (misaligned)
  );

  logic [1:0]        state_p1;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] result_p1;
  logic              sc_fail;
  logic              access;
  logic              ack_take;

  // The LL bit is only consulted when an SC is first seen in IDLE; once the
  // store is on the bus it runs to completion even if the bit is cleared.
`ifdef LLSC_EN
  logic llbit_p1;

  assign sc_fail = is_sc && !llbit_p1 && (state_p1 == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!Rst_n)
      llbit_p1 <= 1'b0;
    else if (flush_i || llbit_clr_i)
      llbit_p1 <= 1'b0;
    else if (ack_take && is_ll)
      llbit_p1 <= 1'b1;
    else if (ack_take && is_sc)
      llbit_p1 <= 1'b0;
  end
`else
  logic unused_llsc;
  assign sc_fail     = 1'b0;
  assign unused_llsc = llbit_clr_i | is_ll;
`endif

  assign access   = (is_load || is_store) && !misaligned && !sc_fail;
  // An ack in the flush cycle is dropped: no capture, no LL-bit update.
  assign ack_take = bus_ack_i && access && !flush_i &&
                    ((state_p1 == ST_IDLE) || (state_p1 == ST_BUSY));

  always_comb begin
    state_nxt = state_p1;
    if (flush_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_p1)
        ST_IDLE: if (access) state_nxt = bus_ack_i ? ST_DONE : ST_BUSY;
        ST_BUSY: if (bus_ack_i) state_nxt = ST_DONE;
        ST_DONE: if (!stall_i) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: FSM state and captured load/SC result ----
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_p1  <= ST_IDLE;
      result_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (ack_take)
        result_p1 <= is_sc ? DATA_W'(1) : (is_load ? ld_data : '0);
    end
  end

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    adel_o     = misaligned && is_load;
    ades_o     = misaligned && is_store;
    bus_req_o  = 1'b0;
    bus_we_o   = 1'b0;
    bus_addr_o = '0;
    bus_sel_o  = 4'b0000;
    bus_data_o = '0;
    if (misaligned) begin
      wreg_o  = 1'b0;
      wdata_o = '0;
    end else if (sc_fail) begin
      wdata_o = '0;
    end else if (access) begin
      if (state_p1 == ST_DONE) begin
        wdata_o = result_p1;
      end else begin
        // Access outstanding: nothing is written back until DONE.
        bus_req_o  = 1'b1;
        stallreq_o = 1'b1;
        bus_we_o   = is_store;
        bus_addr_o = {mem_addr_i[DATA_W-1:2], 2'b00};
        bus_sel_o  = sel;
        bus_data_o = is_store ? st_data : '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
      end
    end
    if (!Rst_n) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stallreq_o = 1'b0;
      adel_o     = 1'b0;
      ades_o     = 1'b0;
      bus_req_o  = 1'b0;
      bus_we_o   = 1'b0;
      bus_addr_o = '0;
      bus_sel_o  = 4'b0000;
      bus_data_o = '0;
    end
  end

endmodule
